fc_decision: RTL
================

FC_DECISION -- requirements
Module: fc_decision

Interface
- REQ-001: Parameter N_IN, default 64: feature beats per frame; legal range 2..1024.
- REQ-002: Parameter DW, default 8: signed width of features and weights.
- REQ-003: Parameter BIAS0, default 0: signed bias added to class-0 score.
- REQ-004: Parameter BIAS1, default 0: signed bias added to class-1 score.
- REQ-005: clk  input  1: single clock; all logic on posedge.
- REQ-006: rst_n  input  1: reset, asynchronous, active-low.
- REQ-007: in_valid  input  1: feature/weight beat present.
- REQ-008: in_ready  output  1: block accepts a beat this cycle.
- REQ-009: feat  input  DW: signed feature value.
- REQ-010: w0  input  DW: signed class-0 weight for this beat.
- REQ-011: w1  input  DW: signed class-1 weight for this beat.
- REQ-012: valid_out  output  1: one-cycle decision strobe.
- REQ-013: data_out  output  1: decision; 1 = class 1, 0 = class 0; meaningful only while valid_out=1.

Function
- REQ-014: A beat SHALL be accepted on a posedge where in_valid=1 and in_ready=1; no other beat affects state.
- REQ-015: FSM states SHALL be ACC, CMP, OUT; ACC->CMP on acceptance of beat N_IN; CMP->OUT unconditionally; OUT->ACC unconditionally.
- REQ-016: in_ready SHALL be 1 in ACC and 0 in CMP and OUT.
- REQ-017: Beat counter SHALL count 0..N_IN-1, increment per accepted beat, and wrap to 0 on acceptance of beat N_IN.
- REQ-018: Accumulators acc0/acc1 SHALL be 2*DW+clog2(N_IN)+1 bits signed, so no overflow occurs; the full signed product feat*wk SHALL be added to acck per accepted beat.
- REQ-019: The first beat of a frame SHALL load acck with feat*wk + BIASk; the bias SHALL be added exactly once per frame.
- REQ-020: In CMP, data_out SHALL be registered as 1 if acc1 > acc0 (signed), else 0; a tie SHALL give 0.
- REQ-021: valid_out SHALL be 1 only in OUT, for exactly one cycle per frame; latency: valid_out high in the cycle beginning 2 posedges after the edge accepting beat N_IN.
- REQ-022: data_out SHALL hold its value until the next CMP.
- REQ-023: in_valid=1 while in_ready=0 SHALL be ignored; upstream holds the beat.
- REQ-024: Back-to-back frames SHALL give at least 2 idle cycles between valid_out pulses and beat acceptance; max throughput: 1 decision per N_IN+2 cycles.

Reset
- REQ-025: On rst_n=0, state SHALL go to ACC, counter to 0, acc0/acc1 to 0, valid_out to 0, data_out to 0, asynchronously.
- REQ-026: Reset mid-frame SHALL discard the partial frame; the first beat after release SHALL start a new frame.
- REQ-027: in_ready SHALL be 1 while reset is asserted and after release.

Configuration
- REQ-028: Macro FC_SCORE_OUT_EN defined: outputs score0 and score1 SHALL be added, each of accumulator width, signed; they carry acc0/acc1 registered in CMP and valid with valid_out.
- REQ-029: Macro FC_SCORE_OUT_EN undefined: score ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Verification
- REQ-030: N_IN=4, biases 0, feat=1 and w0=1, w1=2 on four consecutive beats -> valid_out one cycle, 2 cycles after beat 4; data_out=1; scores 4/8 with FC_SCORE_OUT_EN.
- REQ-031: N_IN=4, w0=w1=3, feat=5 -> tie 60/60; data_out=0.
- REQ-032: N_IN=4, BIAS0=10, feat=1, w0=0, w1=2 -> 10 vs 8; data_out=0, confirming bias is added once.
- REQ-033: in_valid held high continuously for two frames -> in_ready low exactly 2 cycles after each 4th beat; 2 pulses; no beat lost or double-counted.
- REQ-034: rst_n pulsed low after beat 2 -> no valid_out; the next 4 beats yield a correct result from fresh accumulators.
- REQ-035: DW=8, N_IN=64, feat=-128, w1=-128, w0=127 every beat -> acc1=+1048576 with no overflow; data_out=1.

Source files
------------

// File: rtl/fc_decision.sv
`timescale 1ns/1ps
// fc_decision: streaming two-class linear scorer. It accumulates feat*w0 and feat*w1 over N_IN beats,
// then emits a one-cycle decision. Define FC_SCORE_OUT_EN to also expose the final class scores.
module fc_decision #(
    parameter int N_IN  = 64,
    parameter int DW    = 8,
    parameter int BIAS0 = 0,
    parameter int BIAS1 = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [DW-1:0]            feat,
    input  logic signed [DW-1:0]            w0,
    input  logic signed [DW-1:0]            w1,
    output logic                            valid_out,
`ifdef FC_SCORE_OUT_EN
    output logic signed [2*DW+$clog2(N_IN):0] score0,
    output logic signed [2*DW+$clog2(N_IN):0] score1,
`endif
    output logic                            data_out
);

    localparam int CW  = $clog2(N_IN);
    localparam int ACW = 2*DW + CW + 1;
    localparam int PW  = 2*DW;

    localparam logic signed [ACW-1:0] B0 = ACW'(BIAS0);
    localparam logic signed [ACW-1:0] B1 = ACW'(BIAS1);
    localparam logic [CW-1:0]         LAST_BEAT = CW'(N_IN - 1);

    typedef enum logic [1:0] {
        ACC = 2'd0,
        CMP = 2'd1,
        OUT = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt;
    logic signed [ACW-1:0]  acc0;
    logic signed [ACW-1:0]  acc1;
    logic signed [PW-1:0]   prod0;
    logic signed [PW-1:0]   prod1;
    logic                   accept;
    logic                   last;

    assign in_ready = (state_q == ACC);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == LAST_BEAT);

    // Operands are sign-extended to the full product width before multiplying.
    assign prod0 = PW'(feat) * PW'(w0);
    assign prod1 = PW'(feat) * PW'(w1);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept && last) state_d = CMP;
            CMP:     state_d = OUT;
            OUT:     state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // The first beat of a frame reloads the accumulators, which is where the bias enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc0 <= '0;
            acc1 <= '0;
        end else if (accept) begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (cnt == '0) begin
                acc0 <= B0 + ACW'(prod0);
                acc1 <= B1 + ACW'(prod1);
            end else begin
                acc0 <= acc0 + ACW'(prod0);
                acc1 <= acc1 + ACW'(prod1);
            end
        end
    end

    // The decision is captured while leaving CMP, so valid_out is high exactly in OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= 1'b0;
        end else begin
            valid_out <= (state_d == OUT);
            if (state_q == CMP) begin
                data_out <= (acc1 > acc0);
            end
        end
    end

`ifdef FC_SCORE_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score0 <= '0;
            score1 <= '0;
        end else if (state_q == CMP) begin
            score0 <= acc0;
            score1 <= acc1;
        end
    end
`endif

endmodule
